wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter FU_NUMBER, 4, number of functional-unit result sources (0 ld/st, 1 fp, 2 int, 3 branch).
REQ-002 Parameter WB_PORTS, 2, writeback ports toward ROB/register file per cycle.
REQ-003 Parameter Q_DEPTH, 2, entries per FU result queue; power of two and at least 2.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  misprediction flush; discards all buffered results.
REQ-007 fu_update_i  input  FU_NUMBER x ex_update  FU results; .valid marks a push.
REQ-008 fu_stall_o  output  FU_NUMBER  per-FU backpressure; FU shall not present a result while high.
REQ-009 wb_o  output  WB_PORTS x ex_update  granted results; .valid marks an offered result.
REQ-010 wb_ready_i  input  WB_PORTS  same-cycle accept per port.
REQ-011 overflow_o  output  1  sticky error: push into a full queue.

Function
REQ-012 Each FU i SHALL own one FIFO of Q_DEPTH ex_update entries with an occupancy counter.
REQ-013 Push: fu_update_i[i].valid high and flush_i low SHALL write the entry at the tail; a push into an empty queue is visible on wb_o no earlier than the next cycle (latency 1).
REQ-014 fu_stall_o[i] SHALL equal (occupancy[i] == Q_DEPTH), derived from registered state only.
REQ-015 Push while full and no same-cycle pop of that queue SHALL drop the entry and set overflow_o; push while full with same-cycle pop SHALL be accepted.
REQ-016 Arbitration SHALL scan FU indices starting at registered rr_ptr, wrapping modulo FU_NUMBER; first non-empty head goes to port 0, second to port 1, up to WB_PORTS.
REQ-017 Each FU SHALL receive at most one port per cycle; per-FU result order SHALL be preserved.
REQ-018 Ungranted ports SHALL drive .valid low; all ex_update fields of a granted port SHALL equal the queue head unchanged.
REQ-019 Pop: port p granted to FU i with wb_ready_i[p] high SHALL remove the head of queue i at the clock edge.
REQ-020 When at least one pop occurs, rr_ptr SHALL become (highest-priority-order last popped FU index + 1) mod FU_NUMBER; otherwise it is unchanged.
REQ-021 Simultaneous push and pop on the same queue SHALL keep occupancy constant, including at full and at 1.
REQ-022 wb_o need not remain stable while wb_ready_i is low; grants are recomputed each cycle.
REQ-023 flush_i high SHALL force all wb_o .valid low that cycle, ignore pushes and pops, and at the edge empty all queues and set rr_ptr to 0; overflow_o is not cleared.
REQ-024 Read and write pointers SHALL wrap modulo Q_DEPTH; occupancy SHALL be log2(Q_DEPTH)+1 bits wide.

Reset
REQ-025 rst_n low SHALL asynchronously empty all queues, clear all pointers, set rr_ptr to 0, and clear overflow_o.
REQ-026 During and after reset, until the first push, all wb_o .valid, all fu_stall_o, and overflow_o SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results with no partial writeback.

Structure
REQ-028 ex_update, the FU index encoding, and WB_PORTS SHALL live in the shared structs package.
REQ-029 One sub-module, wb_fifo (parameterised depth and payload, push/pop/full/empty/head), SHALL be instantiated FU_NUMBER times.
REQ-030 Arbitration and rr_ptr logic SHALL reside in wb_arbiter itself.

Verification
REQ-031 Reset, then single int push (ticket 3, data 0x55) at cycle 0 with wb_ready_i=11 -> port 0 valid, ticket 3, at cycle 1; queue empty at cycle 2.
REQ-032 All four FUs push in one cycle with rr_ptr=0 and ready=11 -> FU0/FU1 written back next cycle, FU2/FU3 the cycle after, rr_ptr ends at 0.
REQ-033 Int pushes tickets 1,2,3 back-to-back with wb_ready_i=00 -> fu_stall_o[2] high after two; third dropped, overflow_o=1; after ready, tickets 1,2 in order.
REQ-034 Full int queue, ready=01, int push same cycle -> accepted; occupancy stays 2; no overflow.
REQ-035 Three queues non-empty, flush_i pulsed -> wb_o valid low that cycle; all queues empty and rr_ptr=0 next cycle; overflow_o unchanged.
REQ-036 rst_n dropped asynchronously mid-cycle with full queues -> wb_o .valid and fu_stall_o low immediately, before the next clock edge.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// ============================================================================
// Package : wb_arbiter_pkg
// Brief   : Shared writeback types, FU index encoding and default sizing.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package wb_arbiter_pkg;

    localparam int c_FU_NUMBER = 4;
    localparam int c_WB_PORTS  = 2;
    localparam int c_Q_DEPTH   = 2;
    localparam int c_TICKET_W  = 6;
    localparam int c_DATA_W    = 32;

    typedef enum logic [1:0] {
        FU_LDST   = 2'd0,
        FU_FP     = 2'd1,
        FU_INT    = 2'd2,
        FU_BRANCH = 2'd3
    } fu_idx_e;

    typedef struct packed {
        logic                  valid;
        logic [c_TICKET_W-1:0] ticket;
        logic [c_DATA_W-1:0]   data;
        logic                  exc;
    } ex_update_t;

    // (base + off) mod n for base, off < n
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_arbiter_if.sv
// ============================================================================
// Interface : wb_arbiter_if
// Brief     : FU result inputs, backpressure and writeback ports of the arbiter.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int FU_NUMBER = c_FU_NUMBER,
    parameter int WB_PORTS  = c_WB_PORTS
) ();

    logic                          flush_i;
    ex_update_t [FU_NUMBER-1:0]    fu_update_i;
    logic       [FU_NUMBER-1:0]    fu_stall_o;
    ex_update_t [WB_PORTS-1:0]     wb_o;
    logic       [WB_PORTS-1:0]     wb_ready_i;
    logic                          overflow_o;

    modport master (
        output flush_i, fu_update_i, wb_ready_i,
        input  fu_stall_o, wb_o, overflow_o
    );

    modport slave (
        input  flush_i, fu_update_i, wb_ready_i,
        output fu_stall_o, wb_o, overflow_o
    );

endinterface

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module : wb_fifo
// Brief  : Per-FU result FIFO with occupancy counter and synchronous flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_flush,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic      [WIDTH-1:0] o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (c_PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // A push into a full queue still lands when the head leaves on the same edge
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ============================================================================
// Module : wb_arbiter
// Brief  : Round-robin arbiter from per-FU result queues onto WB_PORTS ports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FU_NUMBER = c_FU_NUMBER,
    parameter int WB_PORTS  = c_WB_PORTS,
    parameter int Q_DEPTH   = c_Q_DEPTH
) (
    input wire logic     clk,
    input wire logic     rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int c_FW        = (FU_NUMBER > 1) ? $clog2(FU_NUMBER) : 1;
    localparam int c_PAYLOAD_W = $bits(ex_update_t);

    logic [FU_NUMBER-1:0] w_push;
    logic [FU_NUMBER-1:0] w_pop;
    logic [FU_NUMBER-1:0] w_full;
    logic [FU_NUMBER-1:0] w_empty;
    logic [FU_NUMBER-1:0] w_taken;
    ex_update_t           w_head   [FU_NUMBER];
    logic [WB_PORTS-1:0]  w_gnt_valid;
    logic [c_FW-1:0]      w_gnt_fu [WB_PORTS];
    logic [c_FW-1:0]      w_idx;
    logic [c_FW-1:0]      w_rr_next;
    logic [c_FW-1:0]      r_rr_ptr;
    logic                 r_overflow;
    logic                 w_overflow_set;

    generate
        for (genvar i = 0; i < FU_NUMBER; i++) begin : g_fifo
            assign w_push[i] = bus.fu_update_i[i].valid & ~bus.flush_i;

            wb_fifo #(
                .DEPTH (Q_DEPTH),
                .WIDTH (c_PAYLOAD_W)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (bus.flush_i),
                .i_push  (w_push[i]),
                .i_pop   (w_pop[i]),
                .i_data  (bus.fu_update_i[i]),
                .o_head  (w_head[i]),
                .o_full  (w_full[i]),
                .o_empty (w_empty[i])
            );
        end
    endgenerate

    // Each port takes the next non-empty FU in scan order from r_rr_ptr not yet granted
    always_comb begin
        w_taken     = '0;
        w_idx       = '0;
        w_gnt_valid = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            w_gnt_fu[p] = '0;
            for (int k = 0; k < FU_NUMBER; k++) begin
                w_idx = c_FW'(wrap_idx(int'(r_rr_ptr), k, FU_NUMBER));
                if (!w_gnt_valid[p] && !w_empty[w_idx] && !w_taken[w_idx]) begin
                    w_gnt_valid[p] = 1'b1;
                    w_gnt_fu[p]    = w_idx;
                    w_taken[w_idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            bus.wb_o[p] = '0;
            if (w_gnt_valid[p] && !bus.flush_i) begin
                bus.wb_o[p]       = w_head[w_gnt_fu[p]];
                bus.wb_o[p].valid = 1'b1;
            end
        end
    end

    // Ports are ordered by priority, so the highest accepted port is the last popped FU
    always_comb begin
        w_pop     = '0;
        w_rr_next = r_rr_ptr;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (w_gnt_valid[p] && bus.wb_ready_i[p] && !bus.flush_i) begin
                w_pop[w_gnt_fu[p]] = 1'b1;
                w_rr_next          = c_FW'(wrap_idx(int'(w_gnt_fu[p]), 1, FU_NUMBER));
            end
        end
    end

    assign w_overflow_set = |(w_push & w_full & ~w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_rr_ptr <= bus.flush_i ? '0 : w_rr_next;
            if (w_overflow_set) r_overflow <= 1'b1;
        end
    end

    assign bus.fu_stall_o = w_full;
    assign bus.overflow_o = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ============================================================================
// Module : tb_wb_arbiter
// Brief  : Scenario bench for wb_arbiter with an in-order writeback scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.FU_NUMBER(c_FU_NUMBER), .WB_PORTS(c_WB_PORTS)) bus ();

    wb_arbiter #(
        .FU_NUMBER (c_FU_NUMBER),
        .WB_PORTS  (c_WB_PORTS),
        .Q_DEPTH   (c_Q_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    ex_update_t sb[$];

    function automatic logic [1:0] valids();
        return {bus.wb_o[1].valid, bus.wb_o[0].valid};
    endfunction

    // Every accepted writeback must be the oldest outstanding expected result
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < c_WB_PORTS; p++) begin
                if (bus.wb_o[p].valid && bus.wb_ready_i[p]) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_bad++;
                        $display("FAIL sb_unexpected port%0d: got ticket %0d, expected no writeback", p, bus.wb_o[p].ticket);
                    end else begin
                        ex_update_t e;
                        e = sb.pop_front();
                        if (bus.wb_o[p] !== e) begin
                            n_bad++;
                            $display("FAIL sb_order port%0d: got ticket %0d data %h exc %b, expected ticket %0d data %h exc %b",
                                     p, bus.wb_o[p].ticket, bus.wb_o[p].data, bus.wb_o[p].exc, e.ticket, e.data, e.exc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        bus.flush_i = 1'b0;
        for (int i = 0; i < c_FU_NUMBER; i++) bus.fu_update_i[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic push(input int fu, input int tk, input int dat, input bit expect_out);
        ex_update_t e;
        e        = '0;
        e.valid  = 1'b1;
        e.ticket = c_TICKET_W'(tk);
        e.data   = c_DATA_W'(dat);
        e.exc    = 1'((tk & 1));
        bus.fu_update_i[fu] = e;
        if (expect_out) sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.wb_ready_i = 2'b00;
        sb.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        bus.wb_ready_i = 2'b11;
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL rst_valid: got %b expected 00", valids()); end
        n_cmp++; if (bus.fu_stall_o !== 4'b0000) begin n_bad++; $display("FAIL rst_stall: got %b expected 0000", bus.fu_stall_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL rst_overflow: got %b expected 0", bus.overflow_o); end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL post_rst_valid: got %b expected 00", valids()); end
        n_cmp++; if (bus.fu_stall_o !== 4'b0000) begin n_bad++; $display("FAIL post_rst_stall: got %b expected 0000", bus.fu_stall_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_overflow: got %b expected 0", bus.overflow_o); end
    endtask

    task automatic test_single_push();
        tick();
        bus.wb_ready_i = 2'b11;
        push(FU_INT, 3, 'h55, 1'b1);
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL single_latency: got %b expected 00", valids()); end
        tick();
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b01) begin n_bad++; $display("FAIL single_valid: got %b expected 01", valids()); end
        n_cmp++; if (bus.wb_o[0].ticket !== 6'd3 || bus.wb_o[0].data !== 32'h55)
            begin n_bad++; $display("FAIL single_payload: got ticket %0d data %h expected 3 55", bus.wb_o[0].ticket, bus.wb_o[0].data); end
        tick();
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL single_empty: got %b expected 00", valids()); end
    endtask

    task automatic test_all_four();
        do_reset();
        tick();
        bus.wb_ready_i = 2'b11;
        for (int i = 0; i < c_FU_NUMBER; i++) push(i, 4 + i, 'h100 + i, 1'b1);
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL four_latency: got %b expected 00", valids()); end
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.wb_o[1].ticket, bus.wb_o[0].ticket} !== {6'd5, 6'd4})
            begin n_bad++; $display("FAIL four_first: got %0d/%0d expected 4/5", bus.wb_o[0].ticket, bus.wb_o[1].ticket); end
        tick();
        @(negedge clk);
        n_cmp++; if ({bus.wb_o[1].ticket, bus.wb_o[0].ticket} !== {6'd7, 6'd6})
            begin n_bad++; $display("FAIL four_second: got %0d/%0d expected 6/7", bus.wb_o[0].ticket, bus.wb_o[1].ticket); end
        tick();
        push(FU_LDST, 8, 'h200, 1'b1);
        push(FU_BRANCH, 9, 'h201, 1'b1);
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL four_drained: got %b expected 00", valids()); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.wb_o[0].ticket !== 6'd8 || valids() !== 2'b11)
            begin n_bad++; $display("FAIL four_rr_wrap: got ticket %0d valid %b expected 8 11", bus.wb_o[0].ticket, valids()); end
        tick();
    endtask

    task automatic test_push_at_full();
        do_reset();
        tick();
        push(FU_INT, 10, 'h10, 1'b1);
        tick();
        push(FU_INT, 11, 'h11, 1'b1);
        @(negedge clk);
        n_cmp++; if (bus.fu_stall_o !== 4'b0000) begin n_bad++; $display("FAIL full_one_stall: got %b expected 0000", bus.fu_stall_o); end
        tick();
        bus.wb_ready_i = 2'b01;
        push(FU_INT, 12, 'h12, 1'b1);
        @(negedge clk);
        n_cmp++; if (bus.fu_stall_o !== 4'b0100) begin n_bad++; $display("FAIL full_stall: got %b expected 0100", bus.fu_stall_o); end
        tick();
        bus.wb_ready_i = 2'b00;
        @(negedge clk);
        n_cmp++; if (bus.fu_stall_o !== 4'b0100) begin n_bad++; $display("FAIL full_occ_kept: got %b expected 0100", bus.fu_stall_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL full_no_overflow: got %b expected 0", bus.overflow_o); end
        n_cmp++; if (bus.wb_o[0].ticket !== 6'd11) begin n_bad++; $display("FAIL full_head: got %0d expected 11", bus.wb_o[0].ticket); end
        tick();
        bus.wb_ready_i = 2'b11;
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b01) begin n_bad++; $display("FAIL full_one_port: got %b expected 01", valids()); end
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL full_drained: got %b expected 00", valids()); end
    endtask

    task automatic test_overflow();
        tick();
        bus.wb_ready_i = 2'b00;
        push(FU_INT, 1, 'h1, 1'b1);
        tick();
        push(FU_INT, 2, 'h2, 1'b1);
        tick();
        push(FU_INT, 3, 'h3, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.fu_stall_o !== 4'b0100) begin n_bad++; $display("FAIL ovf_stall: got %b expected 0100", bus.fu_stall_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b expected 0", bus.overflow_o); end
        tick();
        bus.wb_ready_i = 2'b11;
        @(negedge clk);
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b expected 1", bus.overflow_o); end
        n_cmp++; if (valids() !== 2'b01) begin n_bad++; $display("FAIL ovf_one_port: got %b expected 01", valids()); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.fu_stall_o !== 4'b0000) begin n_bad++; $display("FAIL ovf_unstall: got %b expected 0000", bus.fu_stall_o); end
        tick();
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL ovf_dropped: got %b expected 00", valids()); end
    endtask

    task automatic test_flush();
        tick();
        bus.wb_ready_i = 2'b00;
        push(FU_LDST, 20, 'h20, 1'b0);
        push(FU_FP, 21, 'h21, 1'b0);
        push(FU_BRANCH, 22, 'h22, 1'b0);
        tick();
        bus.wb_ready_i = 2'b11;
        bus.flush_i = 1'b1;
        push(FU_LDST, 25, 'h25, 1'b0);
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL flush_valid: got %b expected 00", valids()); end
        tick();
        push(FU_FP, 24, 'h24, 1'b1);
        push(FU_BRANCH, 23, 'h23, 1'b1);
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL flush_empty: got %b expected 00", valids()); end
        n_cmp++; if (bus.overflow_o !== 1'b1) begin n_bad++; $display("FAIL flush_overflow: got %b expected 1", bus.overflow_o); end
        tick();
        @(negedge clk);
        n_cmp++; if (bus.wb_o[0].ticket !== 6'd24) begin n_bad++; $display("FAIL flush_rr_zero: got %0d expected 24", bus.wb_o[0].ticket); end
        tick();
    endtask

    task automatic test_async_reset();
        tick();
        bus.wb_ready_i = 2'b00;
        for (int i = 0; i < c_FU_NUMBER; i++) push(i, 30 + i, 'h300 + i, 1'b0);
        tick();
        for (int i = 0; i < c_FU_NUMBER; i++) push(i, 34 + i, 'h340 + i, 1'b0);
        tick();
        @(negedge clk);
        n_cmp++; if (bus.fu_stall_o !== 4'b1111) begin n_bad++; $display("FAIL arst_full: got %b expected 1111", bus.fu_stall_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL arst_valid: got %b expected 00", valids()); end
        n_cmp++; if (bus.fu_stall_o !== 4'b0000) begin n_bad++; $display("FAIL arst_stall: got %b expected 0000", bus.fu_stall_o); end
        n_cmp++; if (bus.overflow_o !== 1'b0) begin n_bad++; $display("FAIL arst_overflow: got %b expected 0", bus.overflow_o); end
        #1;
        rst_n = 1'b1;
        bus.wb_ready_i = 2'b11;
        tick();
        @(negedge clk);
        n_cmp++; if (valids() !== 2'b00) begin n_bad++; $display("FAIL arst_no_wb: got %b expected 00", valids()); end
    endtask

    initial begin
        clear_inputs();
        bus.wb_ready_i = 2'b00;
        test_reset();
        test_single_push();
        test_all_four();
        test_push_at_full();
        test_overflow();
        test_flush();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d pending expected 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
